// File: rtl/wb_initiator_pkg.sv
// Shared types and constants for the Wishbone classic-cycle initiator.
// Optional feature macro: WB_TIMEOUT_EN (per-beat timeout, see wb_initiator).
package wb_initiator_pkg;

    // Initiator FSM encoding; also exported on the dbg_state port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    // Byte distance between consecutive beats of a burst (32-bit bus).
    localparam logic [31:0] WB_ADR_STRIDE = 32'd4;

    // Read data reported on a beat that ended by timeout.
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    // Word-align a byte address: the two low bits never reach the bus.
    function automatic logic [31:0] align_adr(input logic [31:0] adr);
        return {adr[31:2], 2'b00};
    endfunction

    // Address of the following beat; wraps modulo 2**32.
    function automatic logic [31:0] next_adr(input logic [31:0] adr);
        return adr + WB_ADR_STRIDE;
    endfunction

endpackage

// File: rtl/wb_initiator_timer.sv
// Per-beat timeout counter for wb_initiator.
// Counts enabled cycles since the last clear; o_expired is high on the
// CYCLES-th enabled cycle, so the owner can act on that same clock edge.
// Only instantiated when WB_TIMEOUT_EN is defined.
module wb_initiator_timer #(
    parameter int CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CNT_W = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_hit;

    assign w_hit     = (r_cnt == CNT_W'(CYCLES - 1));
    assign o_expired = i_en && w_hit;

    // Count enabled cycles, holding at the terminal value until cleared.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_hit) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic-cycle initiator: one command (valid/ready) becomes one
// WB cycle of 1..2**LEN_W-1 beats, with one response per beat (valid/ready).
// Optional feature macro: WB_TIMEOUT_EN enables a per-beat timeout of
// TIMEOUT_CYCLES clocks; without it a beat waits for ack/err forever.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; the producer holds payload stable while valid is high and
// ready is low, and valid never depends combinationally on ready.
//
// Beat sequencing: cyc rises one clock after the command is accepted and
// stays high for the whole burst. stb is high only while a beat is waiting
// for ack/err (REQ). Once a beat terminates, stb drops and the response is
// held (RSP) until consumed, so a stalled response never overlaps a strobe.
// An error (or timeout) ends the burst after that beat's response.
module wb_initiator
    import wb_initiator_pkg::*;
#(
    parameter int LEN_W          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    // command port
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [3:0]       cmd_sel,
    input  logic [31:0]      cmd_adr,
    input  logic [31:0]      cmd_dat,
    input  logic [LEN_W-1:0] cmd_len,
    // response port
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_dat,
    output logic             rsp_err,
    output logic             rsp_last,
    // Wishbone initiator port
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i,
    input  logic             wbm_err_i,
    // FSM observation
    output logic [1:0]       dbg_state
);

    state_t             r_state;
    logic               r_cmd_ready;
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_dat;
    logic               r_rsp_err;
    logic               r_rsp_last;
    logic               r_cyc;
    logic               r_stb;
    logic               r_we;
    logic [3:0]         r_sel;
    logic [31:0]        r_adr;
    logic [31:0]        r_dat;
    logic [LEN_W-1:0]   r_beats_left;

    logic               w_accept;
    logic               w_term;
    logic               w_timeout;
    logic               w_final_beat;

    assign w_accept     = cmd_valid && r_cmd_ready;
    assign w_term       = wbm_ack_i || wbm_err_i;
    assign w_final_beat = (r_beats_left == LEN_W'(1));

`ifdef WB_TIMEOUT_EN
    logic w_timer_en;
    logic w_timer_clr;

    // The counter runs only while a beat is outstanding and restarts from
    // zero every time REQ is entered.
    assign w_timer_en  = (r_state == ST_REQ);
    assign w_timer_clr = !w_timer_en;

    wb_initiator_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (w_timer_clr),
        .i_en      (w_timer_en),
        .o_expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // Initiator FSM: command accept, beat issue, response hold and burst stepping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cmd_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_dat    <= '0;
            r_rsp_err    <= 1'b0;
            r_rsp_last   <= 1'b0;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_we         <= 1'b0;
            r_sel        <= '0;
            r_adr        <= '0;
            r_dat        <= '0;
            r_beats_left <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        r_cmd_ready  <= 1'b0;
                        r_cyc        <= 1'b1;
                        r_stb        <= 1'b1;
                        r_we         <= cmd_we;
                        r_sel        <= cmd_sel;
                        r_adr        <= align_adr(cmd_adr);
                        r_dat        <= cmd_dat;
                        // A zero length still performs one beat.
                        r_beats_left <= (cmd_len == '0) ? LEN_W'(1) : cmd_len;
                        r_state      <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (w_term) begin
                        // err takes priority when the slave raises both.
                        r_stb       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_dat   <= r_we ? 32'd0 : wbm_dat_i;
                        r_rsp_err   <= wbm_err_i;
                        r_rsp_last  <= wbm_err_i || w_final_beat;
                        r_state     <= ST_RSP;
                    end else if (w_timeout) begin
                        // Give up on the slave: close the cycle now and
                        // report a terminal error beat.
                        r_stb       <= 1'b0;
                        r_cyc       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_dat   <= TIMEOUT_DATA;
                        r_rsp_err   <= 1'b1;
                        r_rsp_last  <= 1'b1;
                        r_state     <= ST_RSP;
                    end
                end

                ST_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (r_rsp_last) begin
                            // Burst done (or aborted): cyc drops here, so a
                            // new cycle can start no earlier than one idle clock.
                            r_cyc       <= 1'b0;
                            r_cmd_ready <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_adr        <= next_adr(r_adr);
                            r_beats_left <= r_beats_left - LEN_W'(1);
                            r_stb        <= 1'b1;
                            r_state      <= ST_REQ;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_dat   = r_rsp_dat;
    assign rsp_err   = r_rsp_err;
    assign rsp_last  = r_rsp_last;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_stb;
    assign wbm_we_o  = r_we;
    assign wbm_sel_o = r_sel;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_wb_initiator.sv
// Self-checking bench for wb_initiator: behavioural WB slave, response
// monitor feeding an observed queue, expected responses queued per scenario.
// Define WB_TIMEOUT_EN for both RTL and bench to include the timeout scenario.
module tb_wb_initiator;

    localparam int LEN_W = 4;
    localparam int TMO   = 8;

    logic             clk;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_we;
    logic [3:0]       cmd_sel;
    logic [31:0]      cmd_adr;
    logic [31:0]      cmd_dat;
    logic [LEN_W-1:0] cmd_len;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_dat;
    logic             rsp_err;
    logic             rsp_last;
    logic             wbm_cyc_o;
    logic             wbm_stb_o;
    logic             wbm_we_o;
    logic [3:0]       wbm_sel_o;
    logic [31:0]      wbm_adr_o;
    logic [31:0]      wbm_dat_o;
    logic [31:0]      wbm_dat_i;
    logic             wbm_ack_i;
    logic             wbm_err_i;
    logic [1:0]       dbg_state;

    wb_initiator #(
        .LEN_W          (LEN_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_sel   (cmd_sel),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_len   (cmd_len),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .rsp_last  (rsp_last),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i),
        .wbm_err_i (wbm_err_i),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // response = {err, last, dat}
    logic [33:0] exp_q[$];
    logic [33:0] rsp_obs_q[$];
    // beat = {we, adr}, plus the write data seen on that beat
    logic [32:0] beat_q[$];
    logic [31:0] beat_dat_q[$];

    // ---------------- behavioural WB slave ----------------
    int          slv_delay    = 2;
    int          slv_err_beat = 0;
    bit          slv_never    = 1'b0;
    logic [31:0] slv_rdata    = 32'h0;
    int          slv_cnt      = 0;
    int          slv_beat     = 0;

    initial begin
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = 32'h0;
        forever begin
            @(negedge clk);
            if (wbm_cyc_o && wbm_stb_o) begin
                slv_cnt++;
                if (slv_cnt == 1) begin
                    slv_beat++;
                    beat_q.push_back({wbm_we_o, wbm_adr_o});
                    beat_dat_q.push_back(wbm_dat_o);
                end
                if (!slv_never && slv_cnt >= slv_delay) begin
                    wbm_dat_i = slv_rdata + 32'(slv_beat - 1);
                    wbm_ack_i = 1'b1;
                    // error beats raise ack too: err must still win
                    wbm_err_i = (slv_beat == slv_err_beat);
                end
            end else begin
                slv_cnt   = 0;
                wbm_ack_i = 1'b0;
                wbm_err_i = 1'b0;
            end
            if (!wbm_cyc_o) slv_beat = 0;
        end
    end

    // Response monitor: one entry per handshake (sampled mid-cycle).
    initial begin
        forever begin
            @(negedge clk);
            if (rsp_valid && rsp_ready && !reset)
                rsp_obs_q.push_back({rsp_err, rsp_last, rsp_dat});
        end
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic we, input logic [3:0] sel,
                            input logic [31:0] adr, input logic [31:0] dat,
                            input logic [LEN_W-1:0] len);
        int n = 0;
        @(negedge clk);
        cmd_we    = we;
        cmd_sel   = sel;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_len   = len;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            total++;
            bad++;
            $display("FAIL send_cmd: cmd_ready=%0b expected 1 within 50 clk", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        int k = 0;
        while (rsp_obs_q.size() < n && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (rsp_obs_q.size() < n) begin
            total++;
            bad++;
            $display("FAIL wait_rsp: responses=%0d expected %0d", rsp_obs_q.size(), n);
        end
    endtask

    task automatic clear_queues();
        exp_q.delete();
        rsp_obs_q.delete();
        beat_q.delete();
        beat_dat_q.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({cmd_ready, rsp_valid, rsp_err, rsp_last, wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {cmd_ready, rsp_valid, rsp_err, rsp_last, wbm_cyc_o, wbm_stb_o, wbm_we_o});
        end
        total++;
        if ({wbm_adr_o, wbm_dat_o, rsp_dat, wbm_sel_o} !== 100'b0) begin
            bad++;
            $display("FAIL reset_data: adr=%h dat=%h rsp_dat=%h sel=%h expected all 0",
                     wbm_adr_o, wbm_dat_o, rsp_dat, wbm_sel_o);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (cmd_ready !== 1'b1 || dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL reset_release: cmd_ready=%b state=%0d expected 1/0", cmd_ready, dbg_state);
        end
    endtask

    task automatic test_single_read();
        logic [33:0] e, o;
        clear_queues();
        slv_delay = 2;
        slv_rdata = 32'h1234_5678;
        rsp_ready = 1'b1;
        exp_q.push_back({1'b0, 1'b1, 32'h1234_5678});
        send_cmd(1'b0, 4'hF, 32'h3000_0000, 32'h0, 4'd1);
        wait_rsp(1);
        total++;
        if (wbm_cyc_o !== 1'b0) begin
            bad++;
            $display("FAIL single_read cyc_after_rsp: got %b expected 0", wbm_cyc_o);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (beat_q.size() !== 1 || beat_q[0] !== {1'b0, 32'h3000_0000}) begin
            bad++;
            $display("FAIL single_read beats: count=%0d first=%h expected 1/%h",
                     beat_q.size(), (beat_q.size() > 0) ? beat_q[0] : 33'h0, {1'b0, 32'h3000_0000});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (rsp_obs_q.size() == 0) begin
                bad++;
                $display("FAIL single_read rsp: got none expected %h", e);
            end else begin
                o = rsp_obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL single_read rsp: got %h expected %h", o, e);
                end
            end
        end
    endtask

    task automatic test_fill_write();
        logic [33:0] e, o;
        clear_queues();
        slv_delay = 1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++)
            exp_q.push_back({1'b0, (i == 2), 32'h0});
        send_cmd(1'b1, 4'hF, 32'h3000_0010, 32'hA5A5_A5A5, 4'd3);
        wait_rsp(3);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (beat_q.size() !== 3) begin
            bad++;
            $display("FAIL fill_write beat_count: got %0d expected 3", beat_q.size());
        end
        for (int i = 0; i < 3 && i < beat_q.size(); i++) begin
            total++;
            if (beat_q[i] !== {1'b1, 32'h3000_0010 + 32'(4 * i)} || beat_dat_q[i] !== 32'hA5A5_A5A5) begin
                bad++;
                $display("FAIL fill_write beat%0d: got %h/%h expected %h/a5a5a5a5", i,
                         beat_q[i], beat_dat_q[i], {1'b1, 32'h3000_0010 + 32'(4 * i)});
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (rsp_obs_q.size() == 0) begin
                bad++;
                $display("FAIL fill_write rsp: got none expected %h", e);
            end else begin
                o = rsp_obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL fill_write rsp: got %h expected %h", o, e);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [33:0] e, o;
        int k = 0;
        clear_queues();
        slv_delay = 1;
        slv_rdata = 32'h0000_1000;
        rsp_ready = 1'b0;
        exp_q.push_back({1'b0, 1'b0, 32'h0000_1000});
        exp_q.push_back({1'b0, 1'b1, 32'h0000_1001});
        send_cmd(1'b0, 4'h3, 32'h3000_0100, 32'h0, 4'd2);
        while (!rsp_valid && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (wbm_stb_o !== 1'b0 || rsp_valid !== 1'b1 || rsp_dat !== 32'h0000_1000 ||
                rsp_last !== 1'b0 || beat_q.size() !== 1) begin
                bad++;
                $display("FAIL backpressure stall%0d: stb=%b valid=%b dat=%h last=%b beats=%0d expected 0/1/00001000/0/1",
                         i, wbm_stb_o, rsp_valid, rsp_dat, rsp_last, beat_q.size());
            end
        end
        rsp_ready = 1'b1;
        wait_rsp(2);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (beat_q.size() !== 2 || beat_q[1] !== {1'b0, 32'h3000_0104}) begin
            bad++;
            $display("FAIL backpressure beat2: count=%0d adr=%h expected 2/%h", beat_q.size(),
                     (beat_q.size() > 1) ? beat_q[1] : 33'h0, {1'b0, 32'h3000_0104});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (rsp_obs_q.size() == 0) begin
                bad++;
                $display("FAIL backpressure rsp: got none expected %h", e);
            end else begin
                o = rsp_obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL backpressure rsp: got %h expected %h", o, e);
                end
            end
        end
    endtask

    task automatic test_error_abort();
        logic [33:0] e, o;
        clear_queues();
        slv_delay    = 1;
        slv_err_beat = 2;
        rsp_ready    = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 32'h0});
        exp_q.push_back({1'b1, 1'b1, 32'h0});
        send_cmd(1'b1, 4'hF, 32'h3000_0200, 32'h0BAD_F00D, 4'd4);
        wait_rsp(2);
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (beat_q.size() !== 2 || wbm_cyc_o !== 1'b0) begin
            bad++;
            $display("FAIL error_abort beats: count=%0d cyc=%b expected 2/0", beat_q.size(), wbm_cyc_o);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (rsp_obs_q.size() == 0) begin
                bad++;
                $display("FAIL error_abort rsp: got none expected %h", e);
            end else begin
                o = rsp_obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL error_abort rsp: got %h expected %h", o, e);
                end
            end
        end
        total++;
        if (rsp_obs_q.size() !== 0) begin
            bad++;
            $display("FAIL error_abort extra_rsp: got %0d expected 0", rsp_obs_q.size());
        end
        slv_err_beat = 0;
    endtask

    task automatic test_reset_mid_burst();
        int seen_valid = 0;
        clear_queues();
        slv_never = 1'b1;
        rsp_ready = 1'b1;
        send_cmd(1'b0, 4'hF, 32'h3000_0300, 32'h0, 4'd3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid cyc_stb: got %b%b expected 00", wbm_cyc_o, wbm_stb_o);
        end
        slv_never = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen_valid++;
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid cmd_ready: got %b expected 1", cmd_ready);
        end
        repeat (4) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen_valid++;
        end
        total++;
        if (seen_valid !== 0 || rsp_obs_q.size() !== 0 || beat_q.size() !== 1) begin
            bad++;
            $display("FAIL reset_mid no_rsp: valid_cycles=%0d rsps=%0d beats=%0d expected 0/0/1",
                     seen_valid, rsp_obs_q.size(), beat_q.size());
        end
    endtask

    task automatic test_addr_wrap();
        logic [33:0] e, o;
        clear_queues();
        slv_delay = 1;
        rsp_ready = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 32'h0});
        exp_q.push_back({1'b0, 1'b1, 32'h0});
        send_cmd(1'b1, 4'h1, 32'hFFFF_FFFE, 32'h0000_0077, 4'd2);
        wait_rsp(2);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (beat_q.size() !== 2 || beat_q[0] !== {1'b1, 32'hFFFF_FFFC} || beat_q[1] !== {1'b1, 32'h0000_0000}) begin
            bad++;
            $display("FAIL addr_wrap beats: count=%0d b0=%h b1=%h expected 2/%h/%h", beat_q.size(),
                     (beat_q.size() > 0) ? beat_q[0] : 33'h0, (beat_q.size() > 1) ? beat_q[1] : 33'h0,
                     {1'b1, 32'hFFFF_FFFC}, {1'b1, 32'h0});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (rsp_obs_q.size() == 0) begin
                bad++;
                $display("FAIL addr_wrap rsp: got none expected %h", e);
            end else begin
                o = rsp_obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL addr_wrap rsp: got %h expected %h", o, e);
                end
            end
        end
    endtask

    task automatic test_len_zero();
        logic [33:0] e, o;
        clear_queues();
        slv_delay = 3;
        slv_rdata = $urandom_range(32'h7FFF_FFFF, 32'h1000_0000);
        rsp_ready = 1'b1;
        exp_q.push_back({1'b0, 1'b1, slv_rdata});
        send_cmd(1'b0, 4'hC, 32'h3000_0400, 32'h0, 4'd0);
        wait_rsp(1);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (beat_q.size() !== 1) begin
            bad++;
            $display("FAIL len_zero beats: got %0d expected 1", beat_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (rsp_obs_q.size() == 0) begin
                bad++;
                $display("FAIL len_zero rsp: got none expected %h", e);
            end else begin
                o = rsp_obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL len_zero rsp: got %h expected %h", o, e);
                end
            end
        end
    endtask

`ifdef WB_TIMEOUT_EN
    task automatic test_timeout();
        logic [33:0] e, o;
        int k = 0;
        clear_queues();
        slv_never = 1'b1;
        rsp_ready = 1'b0;
        exp_q.push_back({1'b1, 1'b1, 32'hDEAD_BEEF});
        send_cmd(1'b0, 4'hF, 32'h3000_0500, 32'h0, 4'd3);
        while (!rsp_valid && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        total++;
        if (k !== TMO || wbm_cyc_o !== 1'b0 || rsp_err !== 1'b1 || rsp_dat !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL timeout: clk=%0d cyc=%b err=%b dat=%h expected %0d/0/1/deadbeef",
                     k, wbm_cyc_o, rsp_err, rsp_dat, TMO);
        end
        rsp_ready = 1'b1;
        wait_rsp(1);
        repeat (3) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (rsp_obs_q.size() == 0) begin
                bad++;
                $display("FAIL timeout rsp: got none expected %h", e);
            end else begin
                o = rsp_obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL timeout rsp: got %h expected %h", o, e);
                end
            end
        end
        total++;
        if (beat_q.size() !== 1) begin
            bad++;
            $display("FAIL timeout beats: got %0d expected 1", beat_q.size());
        end
        slv_never = 1'b0;
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_sel   = 4'h0;
        cmd_adr   = 32'h0;
        cmd_dat   = 32'h0;
        cmd_len   = '0;
        rsp_ready = 1'b0;

        test_reset();
        test_single_read();
        test_fill_write();
        test_backpressure();
        test_error_abort();
        test_reset_mid_burst();
        test_addr_wrap();
        test_len_zero();
`ifdef WB_TIMEOUT_EN
        test_timeout();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
